bsort_main: RTL and testbench
=============================

BSORT_MAIN -- requirements
Module: bsort_main

Interface
REQ-001 The block SHALL provide parameter MEM_var_26078_26084, default 128: byte base address of the internal sort array on the slave bus.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-low reset: clock and reset are named as the codebase names them (clock, reset).
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-low reset.
REQ-005 start_port  in  1  one-cycle start pulse, sampled in IDLE only.
REQ-006 S_oe_ram  in  2  per-channel slave read enable, channel k = bit k.
REQ-007 S_we_ram  in  2  per-channel slave write enable.
REQ-008 S_addr_ram  in  18  per-channel byte address, channel k = bits [9k+8:9k].
REQ-009 S_Wdata_ram  in  128  per-channel write data, channel k = bits [64k+63:64k]; low 32 bits used.
REQ-010 S_data_ram_size  in  14  per-channel access size in bits, channel k = bits [7k+6:7k].
REQ-011 done_port  out  1  one-cycle pulse when sort completes.
REQ-012 Sout_Rdata_ram  out  128  per-channel read data, zero-extended from 32 bits.
REQ-013 Sout_DataRdy  out  2  per-channel slave access acknowledge.

Function
REQ-014 Array: 100 signed 32-bit words A[0..99]; A[i] at byte address MEM_var_26078_26084 + 4*i.
REQ-015 FSM states: IDLE, COMPARE, PASS_END, DONE; start_port=1 in IDLE -> COMPARE with pass p=0, index j=0, swapped flag cleared.
REQ-016 COMPARE (one cycle per pair): if A[j] > A[j+1] (signed), swap them and set swapped; if j = 98-p -> PASS_END, else j=j+1.
REQ-017 PASS_END (one cycle): if p = 98, or no swap in pass (see REQ-026) -> DONE; else p=p+1, j=0, swapped cleared, -> COMPARE.
REQ-018 DONE: done_port=1 for exactly that cycle, then -> IDLE; result is A sorted ascending, signed, stable multiset.
REQ-019 Latency: start cycle to done cycle = sum over executed passes of (compares+1) + 1; already-sorted array: 101 cycles.
REQ-020 start_port while not IDLE SHALL be ignored; a new start after DONE re-sorts current contents.
REQ-021 Slave access (per channel, both channels independent, same cycle allowed): valid when address word-aligned, within the 400-byte window, size = 32.
REQ-022 Read: Rdata and DataRdy[k] registered, asserted exactly one cycle after oe[k]; invalid address returns 0 with DataRdy still asserted.
REQ-023 Write: valid write updates A in IDLE only, DataRdy[k] one cycle after we[k]; writes while busy or invalid are dropped but still acknowledged; both channels writing same word: channel 1 wins.
REQ-024 Reads while sorting return the current (partially sorted) word.

Reset
REQ-025 reset=0 at a rising edge: FSM -> IDLE, done_port=0, Sout_DataRdy=0, Sout_Rdata_ram=0, p=j=0, A[i] = 99-i (i=0..99); reset mid-sort aborts without done_port.

Configuration
REQ-026 Macro BSORT_EARLY_EXIT_EN: defined -> PASS_END goes to DONE when a pass made no swap; undefined -> always 99 passes (done at fixed 5050 cycles after start).

Verification
REQ-027 Reset, start pulse -> done after 5050 cycles; reads of addresses 128..524 return 0..99 ascending.
REQ-028 With EN: sort, then start again on sorted array -> done 101 cycles after start, contents unchanged.
REQ-029 Write A[0]=-5, A[99]=0x7FFFFFFF over channel 0/1 in IDLE, sort -> A[0]=-5, A[99]=0x7FFFFFFF, signed order holds.
REQ-030 Read address 127 or 528, or size 16 -> DataRdy=1 next cycle, Rdata=0; write there leaves array unchanged.
REQ-031 Assert reset at cycle 20 of a sort -> done_port never pulses, array reads back 99..0.
REQ-032 Both channels read A[5] and A[6] in same cycle -> both DataRdy next cycle with correct values.

Source files
------------

// File: rtl/bsort_main.sv
// bsort_main: bubble sort over an internal array of 100 signed 32-bit words.
// The array is reachable through a two-channel slave bus.
//
// Ports
//   clock           : rising-edge clock for all state
//   reset           : synchronous, active-low reset
//   start_port      : one-cycle start pulse, only honoured in IDLE
//   S_oe_ram[k]     : channel k read enable
//   S_we_ram[k]     : channel k write enable
//   S_addr_ram      : channel k byte address in bits [9k+8:9k]
//   S_Wdata_ram     : channel k write data in bits [64k+63:64k]; only the low 32 bits are used
//   S_data_ram_size : channel k access size in bits, in bits [7k+6:7k]; must be 32
//   done_port       : one-cycle pulse when the sort completes
//   Sout_Rdata_ram  : channel k read data, zero-extended from 32 bits
//   Sout_DataRdy[k] : channel k acknowledge, one cycle after an access
//
// Build option
//   BSORT_EARLY_EXIT_EN : when defined, the sort ends after the first pass
//                         that made no swap. Otherwise all 99 passes run.
module bsort_main #(
  parameter int MEM_var_26078_26084 = 128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_port,
  input  logic [1:0]   S_oe_ram,
  input  logic [1:0]   S_we_ram,
  input  logic [17:0]  S_addr_ram,
  input  logic [127:0] S_Wdata_ram,
  input  logic [13:0]  S_data_ram_size,
  output logic         done_port,
  output logic [127:0] Sout_Rdata_ram,
  output logic [1:0]   Sout_DataRdy
);

  localparam int N = 100;
  // The slave address is 9 bits wide, so the offset from the base wraps mod 512.
  // With the default base of 128, words 96..99 are therefore reached at byte addresses 0..15.
  localparam logic [8:0] BASE = 9'(MEM_var_26078_26084);

  typedef enum logic [1:0] {IDLE, COMPARE, PASS_END, DONE} state_t;

  state_t             state_q, state_d;
  logic [6:0]         p_q, p_d;
  logic [6:0]         j_q, j_d;
  logic               swapped_q, swapped_d;
  logic signed [31:0] a_q [N];
  logic signed [31:0] a_d [N];
  logic [31:0]        rdata_q [2];
  logic [31:0]        rdata_d [2];
  logic [1:0]         rdy_q, rdy_d;

  logic [6:0]         ch_idx [2];
  logic [1:0]         ch_valid;
  logic               early_exit;

  // Upper halves of each write-data lane are not used.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^{S_Wdata_ram[127:96], S_Wdata_ram[63:32]};

  // Per-channel address decode and output packing.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [8:0] off;
      assign off          = S_addr_ram[9*gi +: 9] - BASE;
      assign ch_idx[gi]   = off[8:2];
      assign ch_valid[gi] = (off[1:0] == 2'b00) && (off < 9'd400) &&
                            (S_data_ram_size[7*gi +: 7] == 7'd32);
      assign Sout_Rdata_ram[64*gi +: 64] = {32'd0, rdata_q[gi]};
    end
  endgenerate

  assign Sout_DataRdy = rdy_q;

`ifdef BSORT_EARLY_EXIT_EN
  assign early_exit = !swapped_q;
`else
  logic unused_swapped;
  assign unused_swapped = swapped_q;
  assign early_exit     = 1'b0;
`endif

  // Sort FSM and array next-state.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    j_d       = j_q;
    swapped_d = swapped_q;
    a_d       = a_q;
    done_port = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_port) begin
          state_d   = COMPARE;
          p_d       = 7'd0;
          j_d       = 7'd0;
          swapped_d = 1'b0;
        end
        // Channel 1 is applied last so it wins on a same-word collision.
        for (int k = 0; k < 2; k++) begin
          if (S_we_ram[k] && ch_valid[k]) begin
            a_d[ch_idx[k]] = S_Wdata_ram[64*k +: 32];
          end
        end
      end
      COMPARE: begin
        if (a_q[j_q] > a_q[j_q + 7'd1]) begin
          a_d[j_q]        = a_q[j_q + 7'd1];
          a_d[j_q + 7'd1] = a_q[j_q];
          swapped_d       = 1'b1;
        end
        if (j_q == 7'd98 - p_q) begin
          state_d = PASS_END;
        end else begin
          j_d = j_q + 7'd1;
        end
      end
      PASS_END: begin
        if ((p_q == 7'd98) || early_exit) begin
          state_d = DONE;
        end else begin
          p_d       = p_q + 7'd1;
          j_d       = 7'd0;
          swapped_d = 1'b0;
          state_d   = COMPARE;
        end
      end
      DONE: begin
        done_port = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave read path: reads see the current array, even while a sort is running.
  // Every access is acknowledged, valid or not.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdata_d[k] = 32'd0;
      if (S_oe_ram[k] && ch_valid[k]) begin
        rdata_d[k] = a_q[ch_idx[k]];
      end
    end
    rdy_d = S_oe_ram | S_we_ram;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      p_q       <= 7'd0;
      j_q       <= 7'd0;
      swapped_q <= 1'b0;
      rdy_q     <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        rdata_q[k] <= 32'd0;
      end
      for (int i = 0; i < N; i++) begin
        a_q[i] <= 32'(N - 1 - i);
      end
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      j_q       <= j_d;
      swapped_q <= swapped_d;
      rdy_q     <= rdy_d;
      rdata_q   <= rdata_d;
      a_q       <= a_d;
    end
  end

endmodule

// File: tb/tb_bsort_main.sv
module tb_bsort_main;

  localparam int MEM_BASE = 128;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_port;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [17:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  int compared   = 0;
  int mismatched = 0;
  int model [100];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  bsort_main #(.MEM_var_26078_26084(MEM_BASE)) dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] waddr(input int i);
    return 9'(MEM_BASE + 4 * i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 100; i++) model[i] = 99 - i;
  endtask

  // Reference result: insertion sort, ascending signed.
  task automatic model_sort();
    for (int i = 1; i < 100; i++) begin
      int v = model[i];
      int k = i - 1;
      while (k >= 0 && model[k] > v) begin
        model[k + 1] = model[k];
        k--;
      end
      model[k + 1] = v;
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle on both channels; expected read data is queued at drive time
  // and popped when the acknowledge comes back.
  task automatic access(input logic [1:0] oe, input logic [1:0] we,
                        input logic [8:0] a0, input logic [8:0] a1,
                        input logic [6:0] s0, input logic [6:0] s1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input string tag);
    logic [31:0] ev;
    @(negedge clock);
    S_oe_ram        = oe;
    S_we_ram        = we;
    S_addr_ram      = {a1, a0};
    S_data_ram_size = {s1, s0};
    S_Wdata_ram     = {32'd0, w1, 32'd0, w0};
    if (oe[0]) exp_q0.push_back(e0);
    if (oe[1]) exp_q1.push_back(e1);
    @(negedge clock);
    S_oe_ram = 2'b00;
    S_we_ram = 2'b00;
    check_val({tag, "_rdy"}, 64'(Sout_DataRdy), 64'(oe | we));
    if (Sout_DataRdy[0] && exp_q0.size() > 0) begin
      ev = exp_q0.pop_front();
      check_val({tag, "_ch0"}, Sout_Rdata_ram[63:0], {32'd0, ev});
    end
    if (Sout_DataRdy[1] && exp_q1.size() > 0) begin
      ev = exp_q1.pop_front();
      check_val({tag, "_ch1"}, Sout_Rdata_ram[127:64], {32'd0, ev});
    end
    if (oe != 2'b00) begin
      check_val({tag, "_pending"}, 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic rd(input int ch, input logic [8:0] a, input logic [6:0] sz,
                    input logic [31:0] e, input string tag);
    if (ch == 0) access(2'b01, 2'b00, a, 9'd0, sz, 7'd0, 32'd0, 32'd0, e, 32'd0, tag);
    else         access(2'b10, 2'b00, 9'd0, a, 7'd0, sz, 32'd0, 32'd0, 32'd0, e, tag);
  endtask

  task automatic wr(input int ch, input logic [8:0] a, input logic [6:0] sz,
                    input logic [31:0] d, input string tag);
    if (ch == 0) access(2'b00, 2'b01, a, 9'd0, sz, 7'd0, d, 32'd0, 32'd0, 32'd0, tag);
    else         access(2'b00, 2'b10, 9'd0, a, 7'd0, sz, 32'd0, d, 32'd0, 32'd0, tag);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 100; i++) begin
      rd(i % 2, waddr(i), 7'd32, 32'(model[i]), $sformatf("%s_A%0d", tag, i));
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
  endtask

  // Called right after pulse_start: one cycle since the start cycle has elapsed.
  // exp_lat = 0 skips the latency check.
  task automatic wait_done(input int exp_lat, input string tag);
    int cnt = 1;
    while (!done_port && cnt < 6000) begin
      @(negedge clock);
      cnt++;
    end
    check_val({tag, "_done_seen"}, 64'(done_port), 64'd1);
    if (exp_lat != 0) check_val({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
    @(negedge clock);
    check_val({tag, "_done_pulse"}, 64'(done_port), 64'd0);
  endtask

  initial begin
    int lat_sorted;
    logic seen;
`ifdef BSORT_EARLY_EXIT_EN
    lat_sorted = 101;
`else
    lat_sorted = 5050;
`endif
    reset = 1'b0; start_port = 1'b0; S_oe_ram = 2'b00; S_we_ram = 2'b00;
    S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
    repeat (3) @(negedge clock);
    check_val("rst_done", 64'(done_port), 64'd0);
    check_val("rst_rdy", 64'(Sout_DataRdy), 64'd0);
    check_val("rst_rdata_lo", Sout_Rdata_ram[63:0], 64'd0);
    check_val("rst_rdata_hi", Sout_Rdata_ram[127:64], 64'd0);
    reset = 1'b1;

    model_reset();
    read_all("init");

    // Full sort of the reversed reset contents.
    pulse_start();
    wait_done(5050, "sort1");
    model_sort();
    read_all("sorted1");

    // Re-sort of an already sorted array.
    pulse_start();
    wait_done(lat_sorted, "sort2");
    read_all("sorted2");

    // Invalid accesses: misaligned-below-base, past the window, wrong size.
    rd(0, 9'(127), 7'd32, 32'd0, "bad_addr127");
    rd(1, 9'(528), 7'd32, 32'd0, "bad_addr528");
    rd(0, waddr(0), 7'd16, 32'd0, "bad_size16");
    wr(0, 9'(127), 7'd32, 32'hDEAD0001, "badwr127");
    wr(1, 9'(528), 7'd32, 32'hDEAD0002, "badwr528");
    wr(1, waddr(0), 7'd16, 32'hDEAD0003, "badwr16");
    wr(0, waddr(1) + 9'd2, 7'd32, 32'hDEAD0004, "badwr_unaligned");
    rd(0, waddr(0), 7'd32, 32'(model[0]), "after_bad_A0");
    rd(1, waddr(1), 7'd32, 32'(model[1]), "after_bad_A1");
    rd(0, waddr(96), 7'd32, 32'(model[96]), "after_bad_A96");

    // Both channels read in the same cycle.
    access(2'b11, 2'b00, waddr(5), waddr(6), 7'd32, 7'd32, 32'd0, 32'd0,
           32'(model[5]), 32'(model[6]), "dual_rd");

    // Both channels write the same word: channel 1 wins.
    access(2'b00, 2'b11, waddr(10), waddr(10), 7'd32, 7'd32, 32'd111, 32'd222,
           32'd0, 32'd0, "dual_wr");
    model[10] = 222;
    rd(0, waddr(10), 7'd32, 32'd222, "dual_wr_rb");

    // Extreme values, then sort; a write while busy is dropped.
    wr(0, waddr(0), 7'd32, 32'hFFFFFFFB, "wr_neg5");
    wr(1, waddr(99), 7'd32, 32'h7FFFFFFF, "wr_max");
    model[0] = -5;
    model[99] = 32'h7FFFFFFF;
    pulse_start();
    wr(0, waddr(50), 7'd32, 32'h80000000, "wr_busy");
    wait_done(0, "sort3");
    model_sort();
    read_all("sorted3");
    check_val("sorted3_min_model", 64'(model[0]), 64'(-5));

    // Reset at cycle 20 of a sort aborts it and reloads 99..0.
    pulse_start();
    repeat (19) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5200; c++) begin
      @(negedge clock);
      if (done_port) seen = 1'b1;
    end
    check_val("abort_no_done", 64'(seen), 64'd0);
    model_reset();
    read_all("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
